// File: rtl/serial_frame_ctrl.sv
// serial_frame_ctrl: two-requester round-robin pattern serializer.
// Fetches a word from an 8x8 pattern memory and emits it LSB-first.
module serial_frame_ctrl #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int CNT_W    = 3,
  parameter int IDLE_GAP = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              outp,
  output logic              frame,
  output logic [CNT_W-1:0]  bit_idx,
  output logic              grant_id,
  output logic              done
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] sh_q;
  logic [CNT_W-1:0]  idx_q;
  logic [GAP_W-1:0]  gap_q;
  logic [ADDR_W-1:0] addr_q;
  logic              last_q;
  logic              gid_q;
  logic              pend_q;

  logic gnt0;
  logic gnt1;
  logic hs;
  logic last_bit;
  logic gap_end;

  assign last_bit = (idx_q == CNT_W'(DATA_W - 1));
  assign gap_end  = (gap_q == GAP_W'(IDLE_GAP - 1));
  assign hs       = gnt0 | gnt1;

  // Round-robin grant: on a tie the requester not served last wins.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en && (state_q == IDLE)) begin
      unique case (1'b1)
        (req0_valid && req1_valid): begin
          gnt0 = last_q;
          gnt1 = !last_q;
        end
        (req0_valid && !req1_valid): gnt0 = 1'b1;
        (!req0_valid && req1_valid): gnt1 = 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state logic; en=0 holds the current state.
  always_comb begin
    state_d = state_q;
    if (en) begin
      unique case (state_q)
        IDLE:  if (hs) state_d = LOAD;
        LOAD:  state_d = SHIFT;
        SHIFT: begin
          if (last_bit) begin
            state_d = (IDLE_GAP == 0) ? IDLE : GAP;
          end
        end
        GAP:   if (gap_end) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Pattern memory; writes land regardless of sequencer state.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Sequencer state, capture, shift word, counters and done pending.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      addr_q  <= '0;
      last_q  <= 1'b1;
      gid_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      pend_q  <= 1'b0;
      if (hs) begin
        addr_q <= gnt1 ? req1_addr : req0_addr;
        last_q <= gnt1;
        gid_q  <= gnt1;
      end
      if (state_q == LOAD) begin
        sh_q  <= mem_q[addr_q];
        idx_q <= '0;
      end
      if (state_q == SHIFT) begin
        idx_q <= idx_q + CNT_W'(1);
        if (last_bit) begin
          pend_q <= 1'b1;
          gap_q  <= '0;
        end
      end
      if (state_q == GAP) begin
        gap_q <= gap_q + GAP_W'(1);
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign frame      = (state_q == SHIFT);
  assign outp       = (state_q == SHIFT) && sh_q[idx_q];
  assign bit_idx    = idx_q;
  assign grant_id   = gid_q;
  assign done       = pend_q && en;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// tb_serial_frame_ctrl: directed bench for serial_frame_ctrl.
// Drives after posedge, samples on negedge.
module tb_serial_frame_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       en = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;

  logic       r0v = 1'b0;
  logic       r1v = 1'b0;
  logic [2:0] r0a = '0;
  logic [2:0] r1a = '0;
  logic       r0r, r1r, outp, frame, done, gid;
  logic [2:0] bidx;

  logic       b0v = 1'b0;
  logic       b1v = 1'b0;
  logic [2:0] b0a = '0;
  logic [2:0] b1a = '0;
  logic       b0r, b1r, boutp, bframe, bdone, bgid;
  logic [2:0] bbidx;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       v0;
    logic [2:0] a0;
    logic       r0;
    logic       r1;
    logic       o;
    logic       f;
    logic [2:0] bi;
    logic       d;
    logic       g;
  } vec_t;

  vec_t tv [12];

  always #5 clk = ~clk;

  serial_frame_ctrl #(.IDLE_GAP(1)) dut (
    .clk(clk), .clr(clr), .en(en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .req0_valid(r0v), .req0_addr(r0a), .req0_ready(r0r),
    .req1_valid(r1v), .req1_addr(r1a), .req1_ready(r1r),
    .outp(outp), .frame(frame), .bit_idx(bidx),
    .grant_id(gid), .done(done)
  );

  serial_frame_ctrl #(.IDLE_GAP(0)) dut_b (
    .clk(clk), .clr(clr), .en(en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .req0_valid(b0v), .req0_addr(b0a), .req0_ready(b0r),
    .req1_valid(b1v), .req1_addr(b1a), .req1_ready(b1r),
    .outp(boutp), .frame(bframe), .bit_idx(bbidx),
    .grant_id(bgid), .done(bdone)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_hs0(input string nm);
    bit found;
    found = 1'b0;
    r0v = 1'b1;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (r0r) found = 1'b1;
      tick();
    end
    r0v = 1'b0;
    if (!found) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic xfer(input string nm, input logic [2:0] a,
                      input logic [7:0] expw, input bit ldwr,
                      input logic [7:0] ldwd);
    logic [7:0] w;
    w = '0;
    r0a = a;
    wait_hs0(nm);
    if (ldwr) begin
      wr_en = 1'b1;
      wr_addr = a;
      wr_data = ldwd;
    end
    @(negedge clk);
    chk({nm, "_load_frame"}, frame, 0);
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      w[i] = outp;
      chk({nm, "_frame_bidx"}, {frame, bidx}, {1'b1, 3'(i)});
      tick();
    end
    chk({nm, "_word"}, w, expw);
    @(negedge clk);
    chk({nm, "_done"}, {done, frame}, 2'b10);
    tick();
    @(negedge clk);
    chk({nm, "_done_end"}, done, 0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0] w;
    bit found;
    bit id;

    // A5 frame from cycle N (handshake) to N+11; fields:
    // v0 a0 | r0 r1 outp frame bit_idx done grant_id
    tv[0]  = '{1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    tv[1]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0};
    tv[6]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0};
    tv[8]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0};
    tv[9]  = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0};
    tv[10] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
    tv[11] = '{1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};

    // reset state
    @(negedge clk);
    chk("rst_outs", {r0r, r1r, outp, frame, bidx, done, gid}, 0);
    chk("rst_outs_b", {b0r, b1r, boutp, bframe, bbidx, bdone, bgid}, 0);
    tick();
    clr = 1'b1;
    en = 1'b1;

    // basic frame, table driven
    wr(3'd5, 8'hA5);
    for (int i = 0; i < 12; i++) begin
      r0v = tv[i].v0;
      r0a = tv[i].a0;
      @(negedge clk);
      chk($sformatf("t1_vec%0d", i),
          {r0r, r1r, outp, frame, bidx, done, gid},
          {tv[i].r0, tv[i].r1, tv[i].o, tv[i].f, tv[i].bi,
           tv[i].d, tv[i].g});
      tick();
    end

    // round robin with both requesters held valid
    clr = 1'b0;
    tick();
    clr = 1'b1;
    wr(3'd1, 8'hFF);
    wr(3'd2, 8'h00);
    r0v = 1'b1;
    r0a = 3'd1;
    r1v = 1'b1;
    r1a = 3'd2;
    for (int k = 0; k < 4; k++) begin
      id = (k % 2 == 1);
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        @(negedge clk);
        chk("t2_excl", {r0r & r1r}, 0);
        if (r0r | r1r) begin
          found = 1'b1;
          chk("t2_grant", {r0r, r1r}, {!id, id});
        end
        tick();
      end
      if (!found) chk("t2_timeout", 0, 1);
      @(negedge clk);
      chk("t2_gid", {gid, frame}, {id, 1'b0});
      tick();
      w = '0;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        w[i] = outp;
        tick();
      end
      chk("t2_word", w, id ? 8'h00 : 8'hFF);
      @(negedge clk);
      chk("t2_done", done, 1);
      tick();
    end
    r0v = 1'b0;
    r1v = 1'b0;

    // write into the address being loaded
    wr(3'd3, 8'h0F);
    xfer("t3a", 3'd3, 8'h0F, 1'b1, 8'hF0);
    xfer("t3b", 3'd3, 8'hF0, 1'b0, 8'h00);

    // en freeze mid-frame and on the done cycle
    wr(3'd6, 8'h5A);
    r0a = 3'd6;
    wait_hs0("t4");
    tick();
    w = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      w[i] = outp;
      tick();
    end
    en = 1'b0;
    r1v = 1'b1;
    r1a = 3'd0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t4_frozen", {outp, frame, bidx, r0r, r1r, done},
          {1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0});
      tick();
    end
    en = 1'b1;
    r1v = 1'b0;
    for (int i = 3; i < 8; i++) begin
      @(negedge clk);
      w[i] = outp;
      chk("t4_bidx", {frame, bidx}, {1'b1, 3'(i)});
      tick();
    end
    chk("t4_word", w, 8'h5A);
    en = 1'b0;
    @(negedge clk);
    chk("t4_done_held", {done, frame}, 2'b00);
    tick();
    en = 1'b1;
    @(negedge clk);
    chk("t4_done_late", done, 1);
    tick();
    @(negedge clk);
    chk("t4_done_end", {done, frame}, 2'b00);
    tick();

    // asynchronous reset mid-frame
    wr(3'd4, 8'hF3);
    r0a = 3'd4;
    wait_hs0("t5");
    tick();
    for (int i = 0; i < 4; i++) tick();
    chk("t5_pre", {outp, frame, bidx}, {1'b1, 1'b1, 3'd4});
    #1;
    clr = 1'b0;
    #1;
    chk("t5_async", {r0r, r1r, outp, frame, bidx, done, gid}, 0);
    tick();
    tick();
    clr = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("t5_quiet", {done, frame}, 0);
      tick();
    end
    xfer("t5_mem", 3'd4, 8'h00, 1'b0, 8'h00);

    // zero gap: done coincides with next ready
    wr(3'd7, 8'h81);
    b1v = 1'b1;
    b1a = 3'd7;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (b1r) found = 1'b1;
      tick();
    end
    if (!found) chk("t6_timeout", 0, 1);
    @(negedge clk);
    chk("t6_load", {bframe, bgid}, 2'b01);
    tick();
    w = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      w[i] = boutp;
      tick();
    end
    chk("t6_word", w, 8'h81);
    @(negedge clk);
    chk("t6_done_rdy", {bdone, b1r, bframe}, 3'b110);
    tick();
    @(negedge clk);
    chk("t6_load2", {bframe, bdone}, 2'b00);
    tick();
    @(negedge clk);
    chk("t6_shift2", {bframe, bbidx, boutp}, {1'b1, 3'd0, 1'b1});
    tick();
    b1v = 1'b0;
    for (int c = 0; c < 12; c++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
